// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction memory bus and IF/ID pipeline register bundle
//
// Purpose:
//   Groups the fetch stage's bus signals so the stage, the instruction memory
//   and the decode stage share one connection point.
//
// Signals:
//   rom_addr_o  fetch address driven by the fetch stage (its PC register)
//   rom_ce_o    instruction memory chip enable driven by the fetch stage
//   rom_data_i  instruction word returned combinationally by the memory
//   id_pc_o     PC of the instruction held in IF/ID
//   id_inst_o   instruction held in IF/ID
//   id_valid_o  IF/ID holds a real instruction (0 = bubble)
//
// Modports:
//   master  fetch stage side (drives address, enable and IF/ID)
//   slave   memory/decode side (returns the instruction word)

interface if_fetch_stage_if #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32
);
   logic [ADDR_W-1:0] rom_addr_o;
   logic              rom_ce_o;
   logic [INST_W-1:0] rom_data_i;
   logic [ADDR_W-1:0] id_pc_o;
   logic [INST_W-1:0] id_inst_o;
   logic              id_valid_o;

   modport master (
      output rom_addr_o,
      output rom_ce_o,
      input  rom_data_i,
      output id_pc_o,
      output id_inst_o,
      output id_valid_o
   );

   modport slave (
      input  rom_addr_o,
      input  rom_ce_o,
      output rom_data_i,
      input  id_pc_o,
      input  id_inst_o,
      input  id_valid_o
   );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with stall, branch redirect and exception redirect
//
// Purpose:
//   Holds the PC, drives the instruction memory address/enable, and registers
//   {pc, instruction} into the IF/ID pipeline register for decode.
//   Priority per edge once fetching is enabled: exception, redirect, stall,
//   sequential advance. A flush (exception or redirect) is never held back
//   by a stall.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset (0 = reset)
//   stall_i        hold PC and IF/ID
//   redirect_i     branch/jump taken: flush IF/ID, load redirect_pc_i
//   redirect_pc_i  redirect target (bits [1:0] ignored)
//   exc_i          exception: flush IF/ID, load EXC_VECTOR
//   fetch_bus      master side of if_fetch_stage_if (ROM bus + IF/ID outputs)
//
// Optional feature (macro IF_PERF_CNT_EN):
//   fetch_cnt_o    saturating count of IF/ID loads with valid=1
//   stall_cnt_o    saturating count of edges stalled without a flush

module if_fetch_stage #(
   parameter int                ADDR_W     = 32,
   parameter int                INST_W     = 32,
   parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] EXC_VECTOR = 32'h8000_0004,
   parameter logic [INST_W-1:0] NOP_INST   = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   input  logic              exc_i,
   if_fetch_stage_if.master  fetch_bus
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_cnt_o,
   output logic [31:0]       stall_cnt_o
`endif
);

   // ST_IDLE: first cycle after reset, memory not yet enabled.
   // ST_FETCH: normal operation, chip enable held high.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FETCH = 1'b1
   } state_t;

   // What the current edge does to PC and IF/ID.
   typedef enum logic [2:0] {
      ACT_IDLE     = 3'd0,
      ACT_EXC      = 3'd1,
      ACT_REDIRECT = 3'd2,
      ACT_STALL    = 3'd3,
      ACT_ADVANCE  = 3'd4
   } action_t;

   state_t            state_q;
   state_t            state_nxt;
   action_t           act;

   logic              ce_q;
   logic              ce_nxt;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_nxt;
   logic [ADDR_W-1:0] id_pc_q;
   logic [ADDR_W-1:0] id_pc_nxt;
   logic [INST_W-1:0] id_inst_q;
   logic [INST_W-1:0] id_inst_nxt;
   logic              id_valid_q;
   logic              id_valid_nxt;

   // Redirect targets are word aligned so pc[1:0] stays zero.
   logic [ADDR_W-1:0] redirect_pc_aligned;
   assign redirect_pc_aligned = {redirect_pc_i[ADDR_W-1:2], 2'b00};

   // ---------------------------------------------------------------------
   // State and pipeline registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         ce_q       <= 1'b0;
         pc_q       <= RESET_PC;
         id_pc_q    <= '0;
         id_inst_q  <= NOP_INST;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_nxt;
         ce_q       <= ce_nxt;
         pc_q       <= pc_nxt;
         id_pc_q    <= id_pc_nxt;
         id_inst_q  <= id_inst_nxt;
         id_valid_q <= id_valid_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and datapath selection
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt    = state_q;
      act          = ACT_IDLE;
      ce_nxt       = ce_q;
      pc_nxt       = pc_q;
      id_pc_nxt    = id_pc_q;
      id_inst_nxt  = id_inst_q;
      id_valid_nxt = id_valid_q;

      case (state_q)
         ST_IDLE: begin
            // Memory is disabled this cycle: PC holds, IF/ID takes a bubble.
            state_nxt = ST_FETCH;
            ce_nxt    = 1'b1;
            act       = ACT_IDLE;
         end
         ST_FETCH: begin
            ce_nxt = 1'b1;
            if (exc_i) begin
               act = ACT_EXC;
            end else if (redirect_i) begin
               act = ACT_REDIRECT;
            end else if (stall_i) begin
               act = ACT_STALL;
            end else begin
               act = ACT_ADVANCE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            ce_nxt    = 1'b0;
            act       = ACT_IDLE;
         end
      endcase

      case (act)
         ACT_IDLE: begin
            id_pc_nxt    = '0;
            id_inst_nxt  = NOP_INST;
            id_valid_nxt = 1'b0;
         end
         ACT_EXC: begin
            pc_nxt       = EXC_VECTOR;
            id_pc_nxt    = '0;
            id_inst_nxt  = NOP_INST;
            id_valid_nxt = 1'b0;
         end
         ACT_REDIRECT: begin
            pc_nxt       = redirect_pc_aligned;
            id_pc_nxt    = '0;
            id_inst_nxt  = NOP_INST;
            id_valid_nxt = 1'b0;
         end
         ACT_STALL: begin
            // Everything already defaults to hold.
         end
         ACT_ADVANCE: begin
            // Wraps silently at the top of the address space.
            pc_nxt       = pc_q + ADDR_W'(4);
            id_pc_nxt    = pc_q;
            id_inst_nxt  = fetch_bus.rom_data_i;
            id_valid_nxt = 1'b1;
         end
         default: begin
            id_pc_nxt    = '0;
            id_inst_nxt  = NOP_INST;
            id_valid_nxt = 1'b0;
         end
      endcase
   end

   // All outputs come straight from registers; no input reaches them
   // combinationally.
   assign fetch_bus.rom_addr_o = pc_q;
   assign fetch_bus.rom_ce_o   = ce_q;
   assign fetch_bus.id_pc_o    = id_pc_q;
   assign fetch_bus.id_inst_o  = id_inst_q;
   assign fetch_bus.id_valid_o = id_valid_q;

`ifdef IF_PERF_CNT_EN
   // ---------------------------------------------------------------------
   // Performance counters (saturating)
   // ---------------------------------------------------------------------
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if ((act == ACT_ADVANCE) && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if ((act == ACT_STALL) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed self-checking bench for if_fetch_stage

`timescale 1ns/1ps

module tb_if_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        exc_i;

   int errors = 0;
   int checks = 0;

   if_fetch_stage_if #(.ADDR_W(32), .INST_W(32)) bus ();

   // ROM model: the word stored at each address equals the address.
   assign bus.rom_data_i = bus.rom_addr_o;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_o;
   logic [31:0] stall_cnt_o;
`endif

   if_fetch_stage #(
      .ADDR_W    (32),
      .INST_W    (32),
      .RESET_PC  (32'h0000_0000),
      .EXC_VECTOR(32'h8000_0004),
      .NOP_INST  (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_i      (stall_i),
      .redirect_i   (redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .exc_i        (exc_i),
      .fetch_bus    (bus)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_cnt_o  (fetch_cnt_o),
      .stall_cnt_o  (stall_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 ns past it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic ce, input logic [31:0] addr,
                          input logic [31:0] id_pc, input logic [31:0] id_inst,
                          input logic valid);
      chk({tag, ".ce"},    {31'd0, bus.rom_ce_o},   {31'd0, ce});
      chk({tag, ".addr"},  bus.rom_addr_o,          addr);
      chk({tag, ".idpc"},  bus.id_pc_o,             id_pc);
      chk({tag, ".inst"},  bus.id_inst_o,           id_inst);
      chk({tag, ".valid"}, {31'd0, bus.id_valid_o}, {31'd0, valid});
   endtask

   initial begin
      rst           = 1'b0;
      stall_i       = 1'b0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      exc_i         = 1'b0;

      // Reset state
      #2;
      chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
      chk("reset.fcnt", fetch_cnt_o, 32'd0);
      chk("reset.scnt", stall_cnt_o, 32'd0);
`endif
      #1 rst = 1'b1;

      // 1. Release: first edge enables memory with PC held and a bubble
      tick();
      chk_all("en", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      chk_all("seq0", 1'b1, 32'h4, 32'h0, 32'h0, 1'b1);
      tick();
      chk_all("seq1", 1'b1, 32'h8, 32'h4, 32'h4, 1'b1);
      tick();
      chk_all("seq2", 1'b1, 32'hC, 32'h8, 32'h8, 1'b1);
      tick();
      chk_all("seq3", 1'b1, 32'h10, 32'hC, 32'hC, 1'b1);

      // 2. Stall two cycles at pc=0x10
      stall_i = 1'b1;
      tick();
      chk_all("stall0", 1'b1, 32'h10, 32'hC, 32'hC, 1'b1);
      tick();
      chk_all("stall1", 1'b1, 32'h10, 32'hC, 32'hC, 1'b1);
      stall_i = 1'b0;
      tick();
      chk_all("unstall", 1'b1, 32'h14, 32'h10, 32'h10, 1'b1);
`ifdef IF_PERF_CNT_EN
      chk("cnt.fetch", fetch_cnt_o, 32'd5);
      chk("cnt.stall", stall_cnt_o, 32'd2);
`endif
      tick();
      tick();
      tick();
      chk_all("seq4", 1'b1, 32'h20, 32'h1C, 32'h1C, 1'b1);

      // 3. Redirect to misaligned 0x103 from pc=0x20
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h0000_0103;
      tick();
      chk_all("redir", 1'b1, 32'h100, 32'h0, 32'h0, 1'b0);
      redirect_i = 1'b0;
      tick();
      chk_all("redir_fetch", 1'b1, 32'h104, 32'h100, 32'h100, 1'b1);

      // 4. Exception, redirect and stall together: exception wins
      exc_i         = 1'b1;
      redirect_i    = 1'b1;
      stall_i       = 1'b1;
      redirect_pc_i = 32'h0000_0200;
      tick();
      chk_all("exc", 1'b1, 32'h8000_0004, 32'h0, 32'h0, 1'b0);
      exc_i      = 1'b0;
      redirect_i = 1'b0;
      stall_i    = 1'b0;

      // 5. Wrap at the top of the address space
      redirect_i    = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFC;
      tick();
      chk_all("top", 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
      redirect_i = 1'b0;
      tick();
      chk_all("wrap", 1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);

      // 6. Asynchronous reset between edges
      tick();
      chk_all("prerst", 1'b1, 32'h4, 32'h0, 32'h0, 1'b1);
      #1 rst = 1'b0;
      #1;
      chk_all("asyncrst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
      chk("asyncrst.fcnt", fetch_cnt_o, 32'd0);
      chk("asyncrst.scnt", stall_cnt_o, 32'd0);
`endif
      rst = 1'b1;
      tick();
      chk_all("reen", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
      tick();
      chk_all("reseq", 1'b1, 32'h4, 32'h0, 32'h0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
